// File: rtl/acc_pkg.sv
// Shared opcodes, controller states and the saturation helper used by the
// accumulator bank and its multiplier.
package acc_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_MAC  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_NOP7 = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ITER = 2'b01,
    ST_WB   = 2'b10
  } state_t;

  // Largest or smallest signed value of the given width, sign-extended to 64
  // bits; callers cast it down to their own width.
  function automatic logic [63:0] satBound(input int unsigned width, input logic negative);
    logic [63:0] maxVal;
    maxVal = (64'd1 << (width - 1)) - 64'd1;
    return negative ? ~maxVal : maxVal;
  endfunction

endpackage

// File: rtl/seq_mul.sv
// Unsigned shift-add multiplier: one partial product per cycle for N_BUS
// cycles after start; last_o marks the cycle whose edge adds the final step.
module seq_mul #(
  parameter int N_BUS = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [N_BUS-1:0]   a_i,
  input  logic [N_BUS-1:0]   b_i,
  output logic [2*N_BUS-1:0] prod_o,
  output logic               last_o
);

  localparam int CNT_W = $clog2(N_BUS + 1);

  logic [2*N_BUS-1:0] mcand_q;
  logic [2*N_BUS-1:0] prod_q;
  logic [N_BUS-1:0]   mplr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               run_q;

  assign last_o = run_q && (cnt_q == CNT_W'(1));
  assign prod_o = prod_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_q <= '0;
      prod_q  <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else if (start_i) begin
      mcand_q <= {{N_BUS{1'b0}}, a_i};
      prod_q  <= '0;
      mplr_q  <= b_i;
      cnt_q   <= CNT_W'(N_BUS);
      run_q   <= 1'b1;
    end else if (run_q) begin
      if (mplr_q[0]) begin
        prod_q <= prod_q + mcand_q;
      end
      mcand_q <= mcand_q << 1;
      mplr_q  <= mplr_q >> 1;
      cnt_q   <= cnt_q - CNT_W'(1);
      if (last_o) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/acc_bank.sv
// Signed accumulator bank with single-cycle LOAD/ADD/SUB/CLR and a multi-cycle
// MUL/MAC built on seq_mul, plus result flags and a start/busy/done handshake.
module acc_bank
  import acc_pkg::*;
#(
  parameter int N_BUS  = 16,
  parameter int N_ACC  = 4,
  parameter bit SAT_EN = 1'b0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [2:0]                 i_op,
  input  logic [$clog2(N_ACC)-1:0]   i_sel,
  input  logic signed [N_BUS-1:0]    i_opa,
  input  logic signed [N_BUS-1:0]    i_opb,
  output logic signed [N_BUS-1:0]    o_acc,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_zero,
  output logic                       o_neg,
  output logic                       o_ovf
);

  localparam int SEL_W = $clog2(N_ACC);
  localparam int PW    = 2 * N_BUS;
  localparam logic [N_BUS-1:0] SAT_MAX = N_BUS'(satBound(N_BUS, 1'b0));
  localparam logic [N_BUS-1:0] SAT_MIN = N_BUS'(satBound(N_BUS, 1'b1));

  state_t state_q, state_d;

  logic [N_BUS-1:0] bank_q [N_ACC];
  logic [SEL_W-1:0] sel_q;
  logic             sign_q;
  logic             isMac_q;
  logic             zero_q, neg_q, ovf_q;
  logic             done_q, done_d;

  logic             wrEn;
  logic [SEL_W-1:0] wrIdx;
  logic [N_BUS-1:0] wrData;
  logic             wrOvf;
  logic             mulStart;
  logic             mulLast;

  logic [N_BUS-1:0] opaU, opbU, magA, magB;
  logic [N_BUS-1:0] accSel, accWb;
  logic [N_BUS:0]   addSum, subDiff;
  logic             addOvf, subOvf;
  logic [N_BUS-1:0] addRes, subRes;
  logic [PW-1:0]    prodU, prodS;
  logic [PW:0]      macSum;
  logic             mulOvf, macOvf;
  logic [N_BUS-1:0] macRes, wbRes;
  logic             wbOvf;

  assign accSel = bank_q[i_sel];
  assign accWb  = bank_q[sel_q];
  assign o_acc  = accSel;
  assign o_busy = (state_q != ST_IDLE);
  assign o_done = done_q;
  assign o_zero = zero_q;
  assign o_neg  = neg_q;
  assign o_ovf  = ovf_q;

  // Magnitudes stay unsigned in N_BUS bits so the most-negative operand maps to 2^(N_BUS-1).
  assign opaU = i_opa;
  assign opbU = i_opb;
  assign magA = opaU[N_BUS-1] ? (~opaU + N_BUS'(1)) : opaU;
  assign magB = opbU[N_BUS-1] ? (~opbU + N_BUS'(1)) : opbU;

  assign addSum  = {accSel[N_BUS-1], accSel} + {opaU[N_BUS-1], opaU};
  assign subDiff = {accSel[N_BUS-1], accSel} - {opaU[N_BUS-1], opaU};
  assign addOvf  = addSum[N_BUS] ^ addSum[N_BUS-1];
  assign subOvf  = subDiff[N_BUS] ^ subDiff[N_BUS-1];
  assign addRes  = (SAT_EN && addOvf) ? (addSum[N_BUS] ? SAT_MIN : SAT_MAX) : addSum[N_BUS-1:0];
  assign subRes  = (SAT_EN && subOvf) ? (subDiff[N_BUS] ? SAT_MIN : SAT_MAX) : subDiff[N_BUS-1:0];

  seq_mul #(
    .N_BUS(N_BUS)
  ) u_seq_mul (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .start_i(mulStart),
    .a_i    (magA),
    .b_i    (magB),
    .prod_o (prodU),
    .last_o (mulLast)
  );

  // A value fits N_BUS signed when every bit from N_BUS-1 upward equals the sign.
  assign prodS  = sign_q ? (~prodU + PW'(1)) : prodU;
  assign mulOvf = ~((&prodS[PW-1:N_BUS-1]) | ~(|prodS[PW-1:N_BUS-1]));
  assign macSum = {{(N_BUS+1){accWb[N_BUS-1]}}, accWb} + {prodS[PW-1], prodS};
  assign macOvf = ~((&macSum[PW:N_BUS-1]) | ~(|macSum[PW:N_BUS-1]));
  assign macRes = (SAT_EN && macOvf) ? (macSum[PW] ? SAT_MIN : SAT_MAX) : macSum[N_BUS-1:0];
  assign wbRes  = isMac_q ? macRes : prodS[N_BUS-1:0];
  assign wbOvf  = isMac_q ? macOvf : mulOvf;

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    wrEn     = 1'b0;
    wrIdx    = i_sel;
    wrData   = '0;
    wrOvf    = 1'b0;
    mulStart = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          done_d = 1'b1;
          case (i_op)
            OP_LOAD: begin
              wrEn   = 1'b1;
              wrData = opaU;
            end
            OP_ADD: begin
              wrEn   = 1'b1;
              wrData = addRes;
              wrOvf  = addOvf;
            end
            OP_SUB: begin
              wrEn   = 1'b1;
              wrData = subRes;
              wrOvf  = subOvf;
            end
            OP_CLR: begin
              wrEn   = 1'b1;
              wrData = '0;
            end
            OP_MUL, OP_MAC: begin
              mulStart = 1'b1;
              done_d   = 1'b0;
              state_d  = ST_ITER;
            end
            default: ;
          endcase
        end
      end
      ST_ITER: begin
        if (mulLast) begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        wrEn    = 1'b1;
        wrIdx   = sel_q;
        wrData  = wbRes;
        wrOvf   = wbOvf;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      sel_q   <= '0;
      sign_q  <= 1'b0;
      isMac_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < N_ACC; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (mulStart) begin
        sel_q   <= i_sel;
        sign_q  <= opaU[N_BUS-1] ^ opbU[N_BUS-1];
        isMac_q <= (i_op == OP_MAC);
      end
      if (wrEn) begin
        bank_q[wrIdx] <= wrData;
        zero_q        <= (wrData == '0);
        neg_q         <= wrData[N_BUS-1];
        ovf_q         <= wrOvf;
      end
    end
  end

endmodule

// File: tb/tb_acc_bank.sv
// Directed bench for acc_bank: a wrapping and a saturating instance share the
// same stimulus; expected values are hand-computed constants.
module tb_acc_bank;
  import acc_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [1:0]  sel;
  logic [15:0] opa, opb;

  logic [15:0] acc0, acc1;
  logic        busy0, done0, zero0, neg0, ovf0;
  logic        busy1, done1, zero1, neg1, ovf1;

  int errors = 0;
  int checks = 0;
  int cyc;

  acc_bank #(.N_BUS(16), .N_ACC(4), .SAT_EN(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_sel(sel),
    .i_opa(opa), .i_opb(opb), .o_acc(acc0), .o_busy(busy0), .o_done(done0),
    .o_zero(zero0), .o_neg(neg0), .o_ovf(ovf0)
  );

  acc_bank #(.N_BUS(16), .N_ACC(4), .SAT_EN(1'b1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_sel(sel),
    .i_opa(opa), .i_opb(opb), .o_acc(acc1), .o_busy(busy1), .o_done(done1),
    .o_zero(zero1), .o_neg(neg1), .o_ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One start pulse; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [2:0] o, input logic [1:0] s,
                               input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    sel   = s;
    opa   = a;
    opb   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(output int n);
    n = 1;
    while (busy0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = OP_NOP; sel = 2'd0; opa = '0; opb = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_acc0", acc0, 0);
    checkOutput("rst_busy", busy0, 0);
    checkOutput("rst_done", done0, 0);
    checkOutput("rst_flags", {zero0, neg0, ovf0}, 0);
    @(negedge clk);
    rst = 1'b0;

    // LOAD and done pulse timing
    applyStimulus(OP_LOAD, 2'd1, 16'h1234, 16'h0);
    checkOutput("load_done", done0, 1);
    checkOutput("load_busy", busy0, 0);
    checkOutput("load_acc1", acc0, 16'h1234);
    checkOutput("load_flags", {zero0, neg0, ovf0}, 3'b000);
    @(posedge clk);
    #1;
    checkOutput("load_done_drop", done0, 0);
    sel = 2'd0; #1 checkOutput("load_bank0", acc0, 0);
    sel = 2'd2; #1 checkOutput("load_bank2", acc0, 0);
    sel = 2'd3; #1 checkOutput("load_bank3", acc0, 0);

    // ADD signed overflow: wrap versus clamp
    applyStimulus(OP_LOAD, 2'd0, 16'h7FFF, 16'h0);
    applyStimulus(OP_ADD, 2'd0, 16'h0001, 16'h0);
    checkOutput("add_wrap_acc", acc0, 16'h8000);
    checkOutput("add_wrap_flags", {zero0, neg0, ovf0}, 3'b011);
    checkOutput("add_sat_acc", acc1, 16'h7FFF);
    checkOutput("add_sat_flags", {zero1, neg1, ovf1}, 3'b001);

    // SUB to zero, SUB negative overflow, then CLR
    applyStimulus(OP_LOAD, 2'd2, 16'h0005, 16'h0);
    applyStimulus(OP_SUB, 2'd2, 16'h0005, 16'h0);
    checkOutput("sub_zero_acc", acc0, 0);
    checkOutput("sub_zero_flags", {zero0, neg0, ovf0}, 3'b100);
    applyStimulus(OP_LOAD, 2'd2, 16'h8001, 16'h0);
    applyStimulus(OP_SUB, 2'd2, 16'h0002, 16'h0);
    checkOutput("sub_wrap_acc", acc0, 16'h7FFF);
    checkOutput("sub_wrap_flags", {zero0, neg0, ovf0}, 3'b001);
    checkOutput("sub_sat_acc", acc1, 16'h8000);
    checkOutput("sub_sat_flags", {zero1, neg1, ovf1}, 3'b011);
    applyStimulus(OP_CLR, 2'd2, 16'hFFFF, 16'h0);
    checkOutput("clr_acc", acc0, 0);
    checkOutput("clr_flags", {zero0, neg0, ovf0}, 3'b100);
    checkOutput("clr_sat_flags", {zero1, neg1, ovf1}, 3'b100);

    // NOP pulses done and holds flags
    applyStimulus(OP_NOP7, 2'd2, 16'h1111, 16'h0);
    checkOutput("nop_done", done0, 1);
    checkOutput("nop_flags", {zero0, neg0, ovf0}, 3'b100);

    // MUL with handshake timing, ignored mid-busy LOAD, pre-op read-back
    applyStimulus(OP_LOAD, 2'd3, 16'h0101, 16'h0);
    applyStimulus(OP_MUL, 2'd3, 16'hFFFD, 16'h0007);
    checkOutput("mul_busy_start", busy0, 1);
    checkOutput("mul_done_early", done0, 0);
    cyc = 1;
    while (busy0 && cyc < 40) begin
      if (cyc == 3) checkOutput("mul_preop", acc0, 16'h0101);
      if (cyc == 5) begin
        start = 1'b1; op = OP_LOAD; sel = 2'd0; opa = 16'h5555;
      end
      if (cyc == 6) begin
        start = 1'b0; sel = 2'd3;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("mul_busy_len", cyc - 1, 17);
    checkOutput("mul_done", done0, 1);
    checkOutput("mul_acc", acc0, 16'hFFEB);
    checkOutput("mul_flags", {zero0, neg0, ovf0}, 3'b010);
    sel = 2'd0; #1 checkOutput("mul_ignored_load", acc0, 16'h8000);
    @(posedge clk);
    #1;
    checkOutput("mul_done_drop", done0, 0);

    // MAC, wrapping/saturating MAC and most-negative MUL
    applyStimulus(OP_LOAD, 2'd0, 16'd10, 16'h0);
    applyStimulus(OP_MAC, 2'd0, 16'hFFFC, 16'd6);
    waitDone(cyc);
    checkOutput("mac_done", done0, 1);
    checkOutput("mac_acc", acc0, 16'hFFF2);
    checkOutput("mac_flags", {zero0, neg0, ovf0}, 3'b010);
    applyStimulus(OP_LOAD, 2'd1, 16'h7000, 16'h0);
    applyStimulus(OP_MAC, 2'd1, 16'h0100, 16'h0010);
    waitDone(cyc);
    checkOutput("mac_wrap_acc", acc0, 16'h8000);
    checkOutput("mac_wrap_ovf", ovf0, 1);
    checkOutput("mac_sat_acc", acc1, 16'h7FFF);
    checkOutput("mac_sat_flags", {zero1, neg1, ovf1}, 3'b001);
    applyStimulus(OP_MUL, 2'd0, 16'h8000, 16'h8000);
    waitDone(cyc);
    checkOutput("mulmin_acc", acc0, 0);
    checkOutput("mulmin_flags", {zero0, neg0, ovf0}, 3'b101);
    checkOutput("mulmin_sat_acc", acc1, 0);

    // Reset in the middle of ITER aborts the multiply
    applyStimulus(OP_LOAD, 2'd1, 16'h0042, 16'h0);
    applyStimulus(OP_MUL, 2'd1, 16'd3, 16'd3);
    cyc = 1;
    while (cyc < 8) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", busy0, 0);
    checkOutput("abort_acc1", acc0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done0 !== 1'b0) break;
    end
    checkOutput("abort_no_done", done0, 0);
    checkOutput("abort_idle", busy0, 0);
    applyStimulus(OP_LOAD, 2'd1, 16'h0077, 16'h0);
    checkOutput("post_abort_done", done0, 1);
    checkOutput("post_abort_acc", acc0, 16'h0077);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
